// File: rtl/color_mode_sequencer_if.sv
// Request/grant, mode-FSM command and status bundle for color_mode_sequencer.
// master = requesters plus mode FSM side, slave = sequencer.
interface color_mode_sequencer_if #(
  parameter int unsigned NUM_REQ = 2
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [2*NUM_REQ-1:0] req_target;
  logic [NUM_REQ-1:0]   req_ready;
  logic [1:0]           cmd;
  logic [1:0]           fsm_out;
  logic                 err_clr;
  logic                 busy;
  logic                 done;
  logic [ID_W-1:0]      done_id;
  logic                 done_bad;
  logic                 err;
  logic [1:0]           mode;

  modport master (
    output req_valid, req_target, fsm_out, err_clr,
    input  req_ready, cmd, busy, done, done_id, done_bad, err, mode
  );

  modport slave (
    input  req_valid, req_target, fsm_out, err_clr,
    output req_ready, cmd, busy, done, done_id, done_bad, err, mode
  );
endinterface

// File: rtl/color_mode_sequencer.sv
// Arbitrates requesters for the Color/HSV mode FSM command input and walks the FSM
// step by step to each granted target, confirming fsm_out after every step.
module color_mode_sequencer #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned SETTLE  = 1,
  parameter int unsigned TIMEOUT = 8
) (
  input logic                   clk,
  input logic                   rst,
  color_mode_sequencer_if.slave bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam logic [1:0] ModeBlue = 2'd0;
  localparam logic [1:0] ModeRed  = 2'd1;
  localparam logic [1:0] ModeHsv  = 2'd2;
  localparam logic [1:0] CmdNop   = 2'd3;
  localparam logic [1:0] TgtBad   = 2'd3;
  localparam logic [7:0] SettleCnt  = 8'(SETTLE);
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
  localparam logic [ID_W-1:0] LastId = ID_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {StIdle, StStep, StWait, StDone, StErr, StResync} state_e;

  state_e          r_state, w_state_next;
  logic [1:0]      r_mode, w_mode_next;
  logic [1:0]      r_target, w_target_next;
  logic [ID_W-1:0] r_id, w_id_next;
  logic [ID_W-1:0] r_rr_ptr, w_rr_ptr_next;
  logic            r_bad, w_bad_next;
  logic [7:0]      r_cnt, w_cnt_next;

  logic            w_gnt_found;
  logic [ID_W-1:0] w_gnt_idx;
  logic [1:0]      w_gnt_tgt;
  logic [1:0]      w_step_cmd, w_step_dest, w_exp_out;

  // Round-robin search starting at r_rr_ptr.
  always_comb begin
    int unsigned w_idx;
    w_idx       = 0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = 32'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_gnt_found && bus.req_valid[w_idx[ID_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_gnt_tgt = bus.req_target[{w_gnt_idx, 1'b0} +: 2];

  // Next hop along the BLUE - RED - HSV chain toward r_target.
  always_comb begin
    w_step_cmd  = CmdNop;
    w_step_dest = r_mode;
    unique case (r_mode)
      ModeBlue: begin
        w_step_cmd  = 2'd1;
        w_step_dest = ModeRed;
      end
      ModeRed: begin
        if (r_target == ModeBlue) begin
          w_step_cmd  = 2'd1;
          w_step_dest = ModeBlue;
        end else begin
          w_step_cmd  = 2'd2;
          w_step_dest = ModeHsv;
        end
      end
      ModeHsv: begin
        w_step_cmd  = 2'd0;
        w_step_dest = ModeRed;
      end
      default: ;
    endcase
  end

  assign w_exp_out = (r_mode == ModeBlue) ? 2'd1 : 2'd2;

  always_comb begin
    w_state_next  = r_state;
    w_mode_next   = r_mode;
    w_target_next = r_target;
    w_id_next     = r_id;
    w_rr_ptr_next = r_rr_ptr;
    w_bad_next    = r_bad;
    w_cnt_next    = r_cnt;
    bus.req_ready = '0;
    bus.cmd       = CmdNop;
    bus.done      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_gnt_found) begin
          bus.req_ready[w_gnt_idx] = 1'b1;
          w_target_next = w_gnt_tgt;
          w_id_next     = w_gnt_idx;
          w_rr_ptr_next = (w_gnt_idx == LastId) ? '0 : w_gnt_idx + ID_W'(1);
          w_bad_next    = (w_gnt_tgt == TgtBad);
          w_state_next  = (w_gnt_tgt == TgtBad || w_gnt_tgt == r_mode) ? StDone : StStep;
        end
      end
      StStep: begin
        bus.cmd      = w_step_cmd;
        w_mode_next  = w_step_dest;
        w_cnt_next   = 8'd1;
        w_state_next = StWait;
      end
      StWait: begin
        if (r_cnt >= SettleCnt && bus.fsm_out == w_exp_out) begin
          w_state_next = (r_mode == r_target) ? StDone : StStep;
        end else if (r_cnt == TimeoutCnt) begin
          w_state_next = StErr;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      StDone: begin
        bus.done     = 1'b1;
        w_state_next = StIdle;
      end
      StErr: begin
        if (bus.err_clr) begin
          w_cnt_next   = 8'd0;
          w_state_next = StResync;
        end
      end
      StResync: begin
        // HSV->RED pulse; RED and BLUE ignore it, so the FSM lands in BLUE or RED.
        if (r_cnt == 8'd0) begin
          bus.cmd    = 2'd0;
          w_cnt_next = 8'd1;
        end else if (r_cnt >= SettleCnt) begin
          w_mode_next  = (bus.fsm_out == 2'd1) ? ModeBlue : ModeRed;
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_mode   <= ModeRed;
      r_target <= ModeRed;
      r_id     <= '0;
      r_rr_ptr <= '0;
      r_bad    <= 1'b0;
      r_cnt    <= 8'd0;
    end else begin
      r_state  <= w_state_next;
      r_mode   <= w_mode_next;
      r_target <= w_target_next;
      r_id     <= w_id_next;
      r_rr_ptr <= w_rr_ptr_next;
      r_bad    <= w_bad_next;
      r_cnt    <= w_cnt_next;
    end
  end

  assign bus.busy     = (r_state != StIdle);
  assign bus.done_id  = r_id;
  assign bus.done_bad = (r_state == StDone) && r_bad;
  assign bus.err      = (r_state == StErr) || (r_state == StResync);
  assign bus.mode     = r_mode;
endmodule
